iob_plic_mc: RTL and testbench

Multi-target platform-level interrupt controller with per-source gateways, saturating edge-pending counters, per-target enable, threshold and claim/complete. It sits on the IOb native bus next to the CPU cluster and drives one interrupt line per hart/context. It generalises the previous single-configuration PLIC in three ways: edge/level mode is runtime-selectable per source, edge requests are counted rather than collapsed, and all target arbitration is registered.

---
 rtl/iob_plic_mc_pkg.sv | 23 ++
 rtl/iob_plic_gateway.sv | 93 +++++++++
 rtl/iob_plic_mc.sv | 219 +++++++++++++++++++++
 tb/tb_iob_plic_mc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_plic_mc_pkg.sv
// Shared definitions for the multi-target PLIC: gateway state encoding and
// register map pages/offsets. Widths derived from the top-level parameters
// (SOURCES_BITS, PW, CW) are computed as localparams where they are used.
package iob_plic_mc_pkg;

    // Gateway states; IP for a source is (state == GW_PENDING)
    typedef enum logic [1:0] {
        GW_IDLE      = 2'd0,
        GW_PENDING   = 2'd1,
        GW_INSERVICE = 2'd2
    } gw_state_t;

    // Register map: address bits [11:8] select a page, bits [7:2] the word
    localparam logic [3:0] PAGE_CFG   = 4'h0;  // 0x000 EL, 0x004 IP
    localparam logic [3:0] PAGE_PRIO  = 4'h1;  // 0x100 + 4(s-1)
    localparam logic [3:0] PAGE_IE    = 4'h2;  // 0x200 + 4t
    localparam logic [3:0] PAGE_THR   = 4'h3;  // 0x300 + 4t
    localparam logic [3:0] PAGE_CLAIM = 4'h4;  // 0x400 + 4t

    localparam logic [5:0] IDX_EL = 6'd0;
    localparam logic [5:0] IDX_IP = 6'd1;

endpackage

// File: rtl/iob_plic_gateway.sv
// One interrupt source gateway: input sampling, level/edge FSM and the
// saturating edge-pending counter.
module iob_plic_gateway
    import iob_plic_mc_pkg::*;
#(
    parameter int MAX_PENDING_COUNT = 4,
    parameter int CW = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic clk,
    input  logic cke,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic mode_chg,
    input  logic claim,
    input  logic complete,
    output logic ip
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PENDING_COUNT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    gw_state_t       state_r;
    gw_state_t       state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            src_q_r;
    logic            rise_s;
    logic            claim_ok_s;

    assign rise_s     = src & ~src_q_r;
    // A stale claim (source no longer pending) must not disturb the gateway
    assign claim_ok_s = claim & (state_r == GW_PENDING);
    assign ip         = (state_r == GW_PENDING);

    // Next-state and counter update; a mode change overrides every other event
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (mode_chg) begin
            state_s = GW_IDLE;
            cnt_s   = CNT_ZERO;
        end else if (edge_mode) begin
            // Edge and claim in the same cycle cancel; edges at saturation drop
            if (rise_s && claim_ok_s) begin
                cnt_s = cnt_r;
            end else if (rise_s && (cnt_r != CNT_MAX)) begin
                cnt_s = cnt_r + CNT_ONE;
            end else if (claim_ok_s) begin
                cnt_s = cnt_r - CNT_ONE;
            end else begin
                cnt_s = cnt_r;
            end
            case (state_r)
                GW_IDLE:      state_s = (rise_s || (cnt_r != CNT_ZERO)) ? GW_PENDING : GW_IDLE;
                GW_PENDING:   state_s = claim_ok_s ? GW_INSERVICE : GW_PENDING;
                GW_INSERVICE: state_s = complete ? GW_IDLE : GW_INSERVICE;
                default:      state_s = GW_IDLE;
            endcase
        end else begin
            cnt_s = CNT_ZERO;
            case (state_r)
                GW_IDLE:      state_s = src ? GW_PENDING : GW_IDLE;
                GW_PENDING: begin
                    if (claim_ok_s) begin
                        state_s = GW_INSERVICE;
                    end else if (!src) begin
                        state_s = GW_IDLE;
                    end else begin
                        state_s = GW_PENDING;
                    end
                end
                GW_INSERVICE: state_s = complete ? GW_IDLE : GW_INSERVICE;
                default:      state_s = GW_IDLE;
            endcase
        end
    end

    // Gateway state, counter and source sample registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= GW_IDLE;
            cnt_r   <= CNT_ZERO;
            src_q_r <= 1'b0;
        end else if (cke) begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            src_q_r <= src;
        end
    end

endmodule

// File: rtl/iob_plic_mc.sv
// Multi-target PLIC top: IOb register file, claim/complete decode, gateway
// array and registered per-target priority selection.
module iob_plic_mc
    import iob_plic_mc_pkg::*;
#(
    parameter int N_SOURCES         = 8,
    parameter int N_TARGETS         = 2,
    parameter int PRIORITIES        = 8,
    parameter int MAX_PENDING_COUNT = 4,
    parameter int HAS_THRESHOLD     = 1,
    parameter int ADDR_W            = 16,
    parameter int DATA_W            = 32
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o,
    input  logic [N_SOURCES-1:0]  src_i,
    output logic [N_TARGETS-1:0]  irq_o
);

    localparam int SOURCES_BITS = $clog2(N_SOURCES + 1);
    localparam int SW           = SOURCES_BITS;
    localparam int PW           = $clog2(PRIORITIES);
    localparam int CW           = $clog2(MAX_PENDING_COUNT + 1);

    logic                  ready_r;
    logic                  rvalid_r;
    logic [DATA_W-1:0]     rdata_r;
    logic [N_SOURCES-1:0]  el_r;
    logic [PW-1:0]         prio_r [N_SOURCES];
    logic [N_SOURCES-1:0]  ie_r   [N_TARGETS];
    logic [PW-1:0]         thr_r  [N_TARGETS];
    logic [SW-1:0]         id_r   [N_TARGETS];
    logic [N_TARGETS-1:0]  irq_r;

    logic                  accept_s;
    logic                  wr_s;
    logic                  rd_s;
    logic                  map_ok_s;
    logic [3:0]            page_s;
    logic [5:0]            idx_s;
    logic [DATA_W-1:0]     rdata_s;
    logic [N_SOURCES-1:0]  ip_s;
    logic [N_SOURCES-1:0]  claim_s;
    logic [N_SOURCES-1:0]  complete_s;
    logic [N_SOURCES-1:0]  mode_chg_s;
    logic [PW-1:0]         best_prio_s [N_TARGETS];
    logic [SW-1:0]         best_id_s   [N_TARGETS];

    assign accept_s = cke_i & iob_avalid_i & ready_r;
    assign wr_s     = accept_s & (|iob_wstrb_i);
    assign rd_s     = accept_s & ~(|iob_wstrb_i);
    // Only aligned words inside the 4 KiB window are mapped
    assign map_ok_s = (iob_addr_i[ADDR_W-1:12] == '0) && (iob_addr_i[1:0] == 2'b00);
    assign page_s   = iob_addr_i[11:8];
    assign idx_s    = iob_addr_i[7:2];

    assign iob_ready_o  = ready_r;
    assign iob_rvalid_o = rvalid_r;
    assign iob_rdata_o  = rdata_r;
    assign irq_o        = irq_r;

    for (genvar g = 0; g < N_SOURCES; g++) begin : g_gw
        iob_plic_gateway #(
            .MAX_PENDING_COUNT(MAX_PENDING_COUNT),
            .CW               (CW)
        ) u_gw (
            .clk      (clk_i),
            .cke      (cke_i),
            .rst      (rst_i),
            .src      (src_i[g]),
            .edge_mode(el_r[g]),
            .mode_chg (mode_chg_s[g]),
            .claim    (claim_s[g]),
            .complete (complete_s[g]),
            .ip       (ip_s[g])
        );
    end

    // Read data mux, AND-OR selected over the indexed register arrays
    always_comb begin
        rdata_s = '0;
        if (!map_ok_s) begin
            rdata_s = '0;
        end else begin
            case (page_s)
                PAGE_CFG: begin
                    if (idx_s == IDX_EL) begin
                        rdata_s[N_SOURCES-1:0] = el_r;
                    end else if (idx_s == IDX_IP) begin
                        rdata_s[N_SOURCES-1:0] = ip_s;
                    end else begin
                        rdata_s = '0;
                    end
                end
                PAGE_PRIO: begin
                    for (int s = 0; s < N_SOURCES; s++) begin
                        rdata_s[PW-1:0] = rdata_s[PW-1:0] | ({PW{idx_s == 6'(s)}} & prio_r[s]);
                    end
                end
                PAGE_IE: begin
                    for (int t = 0; t < N_TARGETS; t++) begin
                        rdata_s[N_SOURCES-1:0] = rdata_s[N_SOURCES-1:0] |
                                                 ({N_SOURCES{idx_s == 6'(t)}} & ie_r[t]);
                    end
                end
                PAGE_THR: begin
                    for (int t = 0; t < N_TARGETS; t++) begin
                        rdata_s[PW-1:0] = rdata_s[PW-1:0] | ({PW{idx_s == 6'(t)}} & thr_r[t]);
                    end
                end
                PAGE_CLAIM: begin
                    for (int t = 0; t < N_TARGETS; t++) begin
                        rdata_s[SW-1:0] = rdata_s[SW-1:0] | ({SW{idx_s == 6'(t)}} & id_r[t]);
                    end
                end
                default: rdata_s = '0;
            endcase
        end
    end

    // Claim/complete strobes to the gateways and EL mode-change detection
    always_comb begin
        claim_s    = '0;
        complete_s = '0;
        if (map_ok_s && (page_s == PAGE_CFG) && (idx_s == IDX_EL) && wr_s) begin
            mode_chg_s = iob_wdata_i[N_SOURCES-1:0] ^ el_r;
        end else begin
            mode_chg_s = '0;
        end
        for (int t = 0; t < N_TARGETS; t++) begin
            for (int s = 0; s < N_SOURCES; s++) begin
                // Claim takes the registered winner; id 0 matches no source
                claim_s[s] = claim_s[s] | (rd_s && map_ok_s && (page_s == PAGE_CLAIM) &&
                             (idx_s == 6'(t)) && (id_r[t] == SW'(s + 1)));
                // Complete only counts for sources this target has enabled
                complete_s[s] = complete_s[s] | (wr_s && map_ok_s && (page_s == PAGE_CLAIM) &&
                                (idx_s == 6'(t)) && (iob_wdata_i == DATA_W'(s + 1)) && ie_r[t][s]);
            end
        end
    end

    // Per-target winner: strictly greater keeps the lowest ID on priority ties
    always_comb begin
        for (int t = 0; t < N_TARGETS; t++) begin
            best_prio_s[t] = (HAS_THRESHOLD != 0) ? thr_r[t] : {PW{1'b0}};
            best_id_s[t]   = {SW{1'b0}};
            for (int s = 0; s < N_SOURCES; s++) begin
                best_id_s[t]   = (ip_s[s] && ie_r[t][s] && (prio_r[s] > best_prio_s[t])) ?
                                 SW'(s + 1) : best_id_s[t];
                best_prio_s[t] = (ip_s[s] && ie_r[t][s] && (prio_r[s] > best_prio_s[t])) ?
                                 prio_r[s] : best_prio_s[t];
            end
        end
    end

    // Bus handshake, read response and configuration register writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_r  <= 1'b0;
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            el_r     <= '0;
            for (int s = 0; s < N_SOURCES; s++) begin
                prio_r[s] <= '0;
            end
            for (int t = 0; t < N_TARGETS; t++) begin
                ie_r[t]  <= '0;
                thr_r[t] <= '0;
            end
        end else if (cke_i) begin
            ready_r  <= 1'b1;
            rvalid_r <= rd_s;
            if (rd_s) begin
                rdata_r <= rdata_s;
            end
            if (wr_s && map_ok_s && (page_s == PAGE_CFG) && (idx_s == IDX_EL)) begin
                el_r <= iob_wdata_i[N_SOURCES-1:0];
            end
            for (int s = 0; s < N_SOURCES; s++) begin
                if (wr_s && map_ok_s && (page_s == PAGE_PRIO) && (idx_s == 6'(s))) begin
                    prio_r[s] <= iob_wdata_i[PW-1:0];
                end
            end
            for (int t = 0; t < N_TARGETS; t++) begin
                if (wr_s && map_ok_s && (page_s == PAGE_IE) && (idx_s == 6'(t))) begin
                    ie_r[t] <= iob_wdata_i[N_SOURCES-1:0];
                end
                if ((HAS_THRESHOLD != 0) && wr_s && map_ok_s && (page_s == PAGE_THR) &&
                    (idx_s == 6'(t))) begin
                    thr_r[t] <= iob_wdata_i[PW-1:0];
                end
            end
        end
    end

    // Registered arbitration result and interrupt lines
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_r <= '0;
            for (int t = 0; t < N_TARGETS; t++) begin
                id_r[t] <= '0;
            end
        end else if (cke_i) begin
            for (int t = 0; t < N_TARGETS; t++) begin
                id_r[t]  <= best_id_s[t];
                irq_r[t] <= (best_id_s[t] != {SW{1'b0}});
            end
        end
    end

endmodule

// File: tb/tb_iob_plic_mc.sv
// Directed bench for iob_plic_mc: reads push expected data into a queue that
// a negedge monitor pops whenever rvalid is seen; irq/ready are checked inline.
module tb_iob_plic_mc;

    logic        clk = 1'b0;
    logic        cke;
    logic        rst;
    logic        avalid;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic [7:0]  src;
    logic [1:0]  irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    iob_plic_mc #(
        .N_SOURCES        (8),
        .N_TARGETS        (2),
        .PRIORITIES       (8),
        .MAX_PENDING_COUNT(4),
        .HAS_THRESHOLD    (1),
        .ADDR_W           (16),
        .DATA_W           (32)
    ) dut (
        .clk_i       (clk),
        .cke_i       (cke),
        .rst_i       (rst),
        .iob_avalid_i(avalid),
        .iob_addr_i  (addr),
        .iob_wdata_i (wdata),
        .iob_wstrb_i (wstrb),
        .iob_rvalid_o(rvalid),
        .iob_rdata_o (rdata),
        .iob_ready_o (ready),
        .src_i       (src),
        .irq_o       (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge
    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        avalid = 1'b1;
        addr   = a;
        wdata  = d;
        wstrb  = 4'hF;
        @(posedge clk);
        #1;
        avalid = 1'b0;
        wstrb  = 4'h0;
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [31:0] exp);
        exp_t e;
        e.addr = a;
        e.data = exp;
        exp_q.push_back(e);
        avalid = 1'b1;
        addr   = a;
        wstrb  = 4'h0;
        @(posedge clk);
        #1;
        avalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Read-response monitor
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: got rdata 0x%0h with no read outstanding", rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rdata !== mon_e.data) begin
                    failures++;
                    $display("FAIL rd_0x%0h: got 0x%0h expected 0x%0h", mon_e.addr, rdata, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        cke = 1'b1; rst = 1'b1; avalid = 1'b0; addr = 16'h0;
        wdata = 32'h0; wstrb = 4'h0; src = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 32'h0);
        chk("rst_irq", irq, 32'h0);
        chk("rst_rvalid", rvalid, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", ready, 32'h1);
        bus_rd(16'h0004, 32'h0);

        // Level source 3, priority 5, enabled on target 0
        bus_wr(16'h0108, 32'd5);
        bus_wr(16'h0200, 32'h04);
        bus_rd(16'h0108, 32'd5);
        bus_rd(16'h0200, 32'h04);
        src[2] = 1'b1;
        idle(1);
        chk("lvl_irq_k", irq[0], 32'h0);
        idle(1);
        chk("lvl_irq_k1", irq[0], 32'h1);
        bus_rd(16'h0004, 32'h04);
        bus_rd(16'h0400, 32'd3);
        chk("claim_irq_hold", irq[0], 32'h1);
        idle(1);
        chk("claim_irq_drop", irq[0], 32'h0);
        bus_wr(16'h0400, 32'd3);
        idle(2);
        chk("recomplete_irq", irq[0], 32'h1);
        bus_rd(16'h0400, 32'd3);
        src[2] = 1'b0;
        bus_wr(16'h0400, 32'd3);
        idle(2);
        chk("lvl_clear", irq[0], 32'h0);

        // Priority tie between sources 2 and 5
        bus_wr(16'h0104, 32'd4);
        bus_wr(16'h0110, 32'd4);
        bus_wr(16'h0200, 32'h12);
        src[1] = 1'b1; src[4] = 1'b1;
        idle(2);
        chk("tie_irq", irq[0], 32'h1);
        bus_rd(16'h0400, 32'd2);
        idle(1);
        bus_rd(16'h0400, 32'd5);
        src[1] = 1'b0; src[4] = 1'b0;
        bus_wr(16'h0400, 32'd2);
        bus_wr(16'h0400, 32'd5);
        idle(2);
        chk("tie_clear", irq[0], 32'h0);

        // Threshold equal to the priority blocks; lowering it releases
        bus_wr(16'h0300, 32'd4);
        bus_rd(16'h0300, 32'd4);
        src[1] = 1'b1; src[4] = 1'b1;
        idle(3);
        chk("thr_block", irq[0], 32'h0);
        bus_rd(16'h0004, 32'h12);
        bus_rd(16'h0400, 32'd0);
        bus_wr(16'h0300, 32'd3);
        chk("thr_write_k", irq[0], 32'h0);
        idle(1);
        chk("thr_write_k1", irq[0], 32'h1);
        src[1] = 1'b0; src[4] = 1'b0;
        bus_wr(16'h0300, 32'd0);
        bus_wr(16'h0200, 32'h0);
        idle(2);
        chk("cfg_clear", irq[0], 32'h0);

        // Unmapped accesses
        bus_wr(16'h0800, 32'hFFFF_FFFF);
        bus_wr(16'h1000, 32'hFF);
        bus_rd(16'h0800, 32'h0);
        bus_rd(16'h0000, 32'h0);

        // Edge source 1: six pulses saturate at four claims
        bus_wr(16'h0000, 32'h01);
        bus_wr(16'h0100, 32'd2);
        bus_wr(16'h0200, 32'h01);
        bus_rd(16'h0000, 32'h01);
        for (int i = 0; i < 6; i++) begin
            src[0] = 1'b1;
            idle(1);
            src[0] = 1'b0;
            idle(1);
        end
        idle(1);
        bus_rd(16'h0004, 32'h01);
        for (int i = 0; i < 4; i++) begin
            bus_rd(16'h0400, 32'd1);
            bus_wr(16'h0400, 32'd1);
            idle(2);
        end
        bus_rd(16'h0400, 32'd0);
        chk("edge_drained_irq", irq[0], 32'h0);

        // Complete on a target without the source enabled is ignored
        bus_wr(16'h0118, 32'd3);
        bus_wr(16'h0200, 32'h40);
        bus_wr(16'h0204, 32'h00);
        src[6] = 1'b1;
        idle(2);
        chk("s7_irq", irq[0], 32'h1);
        bus_rd(16'h0400, 32'd7);
        src[6] = 1'b0;
        bus_wr(16'h0404, 32'd7);
        src[6] = 1'b1;
        idle(3);
        chk("ign_irq0", irq[0], 32'h0);
        chk("ign_irq1", irq[1], 32'h0);
        bus_rd(16'h0004, 32'h0);
        bus_wr(16'h0400, 32'd7);
        idle(2);
        chk("svc_complete", irq[0], 32'h1);

        // Reset while source 4 is pending, with a read on the reset edge
        bus_wr(16'h010C, 32'd6);
        bus_wr(16'h0200, 32'h08);
        src[6] = 1'b0; src[3] = 1'b1;
        idle(3);
        chk("pre_rst_irq", irq[0], 32'h1);
        bus_rd(16'h010C, 32'd6);
        rst = 1'b1; avalid = 1'b1; addr = 16'h0004; wstrb = 4'h0;
        @(posedge clk);
        #1;
        avalid = 1'b0; src = 8'h00;
        chk("mid_rst_irq", irq, 32'h0);
        chk("mid_rst_ready", ready, 32'h0);
        chk("mid_rst_rvalid", rvalid, 32'h0);
        chk("mid_rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        idle(1);
        chk("ready_after_rst2", ready, 32'h1);
        bus_rd(16'h0000, 32'h0);
        bus_rd(16'h010C, 32'h0);
        bus_rd(16'h0200, 32'h0);
        bus_rd(16'h0004, 32'h0);
        chk("post_rst_irq", irq, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        chk("reads_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
